// File: rtl/sc_buf_pkg.sv
// Shared definitions for the stack/queue scratch buffer.
//   mode_t           : storage order selector (LIFO or FIFO)
//   default_af_level : default almost-full threshold (four words below capacity)
package sc_buf_pkg;

    typedef enum logic {
        MODE_LIFO = 1'b0,
        MODE_FIFO = 1'b1
    } mode_t;

    function automatic int default_af_level(input int depth);
        return (1 << depth) - 4;
    endfunction

endpackage

// File: rtl/sc_ram_rf.sv
// Simple dual-port RAM. The write happens in the same cycle as the read, and
// the read returns the word that was stored before that write (read-first).
// Read data is registered.
//   clk      : clock
//   reset    : synchronous reset of the read-data register only
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data keeps its value when rd_en is low
//   rd_addr  : read address
//   rd_data  : registered read data
module sc_ram_rf #(
    parameter int data_width = 32,
    parameter int buf_depth  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [buf_depth-1:0]  wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [buf_depth-1:0]  rd_addr,
    output logic [data_width-1:0] rd_data
);

    logic [data_width-1:0] mem_reg [0:(1<<buf_depth)-1];
    logic [data_width-1:0] rd_data_reg;

    // The array has no reset, so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // The non-blocking write above makes a same-address read return the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/sc_stack_queue.sv
// Single-clock buffer. The storage order (LIFO or FIFO) is chosen at run time.
// Read data is registered and is qualified by a one-cycle strobe.
//   clk, reset     : clock and synchronous active-high reset
//   clear          : synchronous flush; also loads the requested mode
//   mode           : requested order (0 LIFO, 1 FIFO); cur_mode is the order in effect
//   wr, data_in    : write request and write data
//   rd             : read request; data_out/data_valid follow one cycle later
//   full, empty, almost_full, almost_empty, use_words : occupancy status
//   overflow, underflow : sticky flags for rejected writes and rejected reads
module sc_stack_queue
    import sc_buf_pkg::*;
#(
    parameter int data_width = 32,
    parameter int buf_depth  = 12,
    parameter int af_level   = default_af_level(buf_depth),
    parameter int ae_level   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  mode,
    input  logic                  wr,
    input  logic [data_width-1:0] data_in,
    input  logic                  rd,
    output logic [data_width-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [buf_depth:0]    use_words,
    output logic                  cur_mode,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [buf_depth:0]   CAP     = {1'b1, {buf_depth{1'b0}}};
    localparam logic [buf_depth:0]   CNT_ONE = 1;
    localparam logic [buf_depth-1:0] PTR_ONE = 1;

    logic [buf_depth:0]   count_reg;
    logic [buf_depth-1:0] wr_ptr_reg;
    logic [buf_depth-1:0] rd_ptr_reg;
    mode_t                cur_mode_reg;
    logic                 overflow_reg;
    logic                 underflow_reg;
    logic                 data_valid_reg;

    logic                 active;
    logic                 rd_acc;
    logic                 wr_acc;
    logic [buf_depth-1:0] lifo_top;
    logic [buf_depth-1:0] lifo_slot;
    logic [buf_depth-1:0] ram_waddr;
    logic [buf_depth-1:0] ram_raddr;

    assign empty        = (count_reg == '0);
    assign full         = (count_reg == CAP);
    assign almost_full  = (int'(count_reg) >= af_level);
    assign almost_empty = (int'(count_reg) <= ae_level);
    assign use_words    = count_reg;
    assign cur_mode     = cur_mode_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
    assign data_valid   = data_valid_reg;

    // reset and clear drop the same-cycle requests, so the RAM is left untouched.
    assign active = !reset && !clear;
    assign rd_acc = active && rd && !empty;
    assign wr_acc = active && wr && (!full || rd_acc);

    // Only the low bits of the stack pointer are used. At count == CAP the low
    // bits are zero, so the subtraction wraps round to CAP-1, which is the top slot.
    assign lifo_slot = count_reg[buf_depth-1:0];
    assign lifo_top  = count_reg[buf_depth-1:0] - PTR_ONE;

    // A LIFO push+pop overwrites the top slot. Because the RAM is read-first,
    // the read still returns the old top.
    always_comb begin
        ram_waddr = lifo_slot;
        ram_raddr = lifo_top;
        if (cur_mode_reg == MODE_FIFO) begin
            ram_waddr = wr_ptr_reg;
            ram_raddr = rd_ptr_reg;
        end else if (rd_acc) begin
            ram_waddr = lifo_top;
        end
    end

    sc_ram_rf #(
        .data_width (data_width),
        .buf_depth  (buf_depth)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (ram_waddr),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (ram_raddr),
        .rd_data (data_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            cur_mode_reg   <= MODE_LIFO;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            data_valid_reg <= 1'b0;
        end else if (clear) begin
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            cur_mode_reg   <= mode_t'(mode);
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            data_valid_reg <= 1'b0;
        end else begin
            data_valid_reg <= rd_acc;
            if (wr && !wr_acc) begin
                overflow_reg <= 1'b1;
            end
            if (rd && empty) begin
                underflow_reg <= 1'b1;
            end

            case ({wr_acc, rd_acc})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase

            // The FIFO pointers stay at zero while in LIFO mode, so they
            // start from zero after a switch to FIFO.
            if (cur_mode_reg == MODE_FIFO) begin
                if (wr_acc) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                end
                if (rd_acc) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                end
            end else begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end

            // The mode changes only when the buffer is empty and no write is
            // arriving, so stored words are never reordered.
            if (empty && !wr) begin
                cur_mode_reg <= mode_t'(mode);
            end
        end
    end

endmodule

// File: tb/tb_sc_stack_queue.sv
module tb_sc_stack_queue;

    localparam int DW  = 8;
    localparam int BD  = 2;
    localparam int CAP = 4;
    localparam int AF  = 3;
    localparam int AE  = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          mode = 1'b0;
    logic          wr = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [BD:0]   use_words;
    logic          cur_mode;
    logic          overflow;
    logic          underflow;

    sc_stack_queue #(
        .data_width (DW),
        .buf_depth  (BD),
        .af_level   (AF),
        .ae_level   (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .mode         (mode),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .use_words    (use_words),
        .cur_mode     (cur_mode),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cycle  = 0;
    bit check_en = 1'b0;
    logic mode_drv = 1'b0;

    // The model holds the stored words as a queue in arrival order.
    logic [DW-1:0] m_q[$];
    logic          m_mode  = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          m_unf   = 1'b0;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_dout  = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, n_cycle);
        end
    endfunction

    function automatic void model_step(input logic r, input logic c, input logic m,
                                       input logic w, input logic [DW-1:0] d, input logic rr);
        bit was_empty;
        bit ra;
        bit wa;
        if (r) begin
            m_q.delete();
            m_mode = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_dout = '0;
        end else if (c) begin
            m_q.delete();
            m_mode = m; m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
        end else begin
            was_empty = (m_q.size() == 0);
            ra = rr && !was_empty;
            wa = w && ((m_q.size() < CAP) || ra);
            if (w && !wa) m_ovf = 1'b1;
            if (rr && was_empty) m_unf = 1'b1;
            m_valid = ra;
            if (ra) m_dout = m_mode ? m_q.pop_front() : m_q.pop_back();
            if (wa) m_q.push_back(d);
            if (was_empty && !w) m_mode = m;
        end
    endfunction

    // Checks every output against the model a little after each rising edge.
    always @(posedge clk) begin
        #2;
        if (check_en) begin
            chk("data_valid",   data_valid,   m_valid);
            chk("data_out",     data_out,     m_dout);
            chk("use_words",    use_words,    m_q.size());
            chk("full",         full,         m_q.size() == CAP);
            chk("empty",        empty,        m_q.size() == 0);
            chk("almost_full",  almost_full,  m_q.size() >= AF);
            chk("almost_empty", almost_empty, m_q.size() <= AE);
            chk("cur_mode",     cur_mode,     m_mode);
            chk("overflow",     overflow,     m_ovf);
            chk("underflow",    underflow,    m_unf);
        end
    end

    task automatic step(input logic r, input logic c, input logic w,
                        input logic [DW-1:0] d, input logic rr);
        reset = r; clear = c; mode = mode_drv; wr = w; data_in = d; rd = rr;
        @(posedge clk);
        model_step(r, c, mode_drv, w, d, rr);
        n_cycle++;
        @(negedge clk);
        $display("cyc %0d rst=%0b clr=%0b mode=%0b wr=%0b din=%02h rd=%0b -> dout=%02h vld=%0b use=%0d cm=%0b ovf=%0b unf=%0b",
                 n_cycle, r, c, mode_drv, w, d, rr, data_out, data_valid, use_words, cur_mode, overflow, underflow);
    endtask

    task automatic push(input logic [DW-1:0] d); step(1'b0, 1'b0, 1'b1, d, 1'b0); endtask
    task automatic pop();                        step(1'b0, 1'b0, 1'b0, '0, 1'b1); endtask
    task automatic idle();                       step(1'b0, 1'b0, 1'b0, '0, 1'b0); endtask

    task automatic pop_expect(input string name, input logic [DW-1:0] exp);
        pop();
        chk({name, "_valid"}, data_valid, 1'b1);
        chk(name, data_out, exp);
    endtask

    initial begin
        check_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_aempty", almost_empty, 1'b1);
        chk("rst_dout", data_out, 8'h00);

        // LIFO order
        push(8'h11); push(8'h22); push(8'h33);
        pop_expect("lifo_pop1", 8'h33);
        pop_expect("lifo_pop2", 8'h22);
        pop_expect("lifo_pop3", 8'h11);
        idle();
        chk("lifo_empty", empty, 1'b1);
        chk("lifo_use", use_words, 3'd0);

        // FIFO order, then push/pop pairs across the pointer wrap
        mode_drv = 1'b1;
        idle();
        chk("fifo_mode", cur_mode, 1'b1);
        push(8'h0A); push(8'h0B); push(8'h0C);
        pop_expect("fifo_pop1", 8'h0A);
        pop_expect("fifo_pop2", 8'h0B);
        pop_expect("fifo_pop3", 8'h0C);
        push(8'h40);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
            chk("wrap_pair", data_out, 8'(8'h40 + i - 1));
            chk("wrap_use", use_words, 3'd1);
        end
        pop_expect("wrap_last", 8'h46);

        // Full boundary in LIFO mode
        mode_drv = 1'b0;
        idle();
        chk("lifo_mode", cur_mode, 1'b0);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        chk("full_flag", full, 1'b1);
        chk("full_af", almost_full, 1'b1);
        chk("full_use", use_words, 3'd4);
        push(8'h55);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_use", use_words, 3'd4);
        step(1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
        chk("full_pp_dout", data_out, 8'h04);
        chk("full_pp_use", use_words, 3'd4);
        pop_expect("full_pop", 8'h66);
        pop_expect("drain1", 8'h03);
        pop_expect("drain2", 8'h02);
        pop_expect("drain3", 8'h01);

        // Underflow, and a write together with a read on empty
        pop();
        chk("unf_flag", underflow, 1'b1);
        chk("unf_valid", data_valid, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
        chk("unf_wr_use", use_words, 3'd1);
        chk("unf_wr_valid", data_valid, 1'b0);
        pop_expect("unf_pop", 8'h77);

        // Mode change requested while holding data is deferred
        push(8'h01); push(8'h02);
        mode_drv = 1'b1;
        pop_expect("defer_pop1", 8'h02);
        chk("defer_mode1", cur_mode, 1'b0);
        pop_expect("defer_pop2", 8'h01);
        chk("defer_mode2", cur_mode, 1'b0);
        idle();
        chk("defer_mode3", cur_mode, 1'b1);

        // Clear with data held and overflow set
        push(8'h91); push(8'h92); push(8'h93); push(8'h94);
        push(8'h95);
        pop_expect("clr_pre_pop", 8'h91);
        chk("clr_pre_ovf", overflow, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0);
        chk("clr_use", use_words, 3'd0);
        chk("clr_empty", empty, 1'b1);
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_valid", data_valid, 1'b0);
        idle();
        chk("clr_wr_dropped", use_words, 3'd0);

        // Reset during a pop
        push(8'hA1); push(8'hA2);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk("rst_pop_valid", data_valid, 1'b0);
        chk("rst_pop_dout", data_out, 8'h00);
        chk("rst_pop_use", use_words, 3'd0);
        idle();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_stack_queue.md
Name: sc_stack_queue

Overview:
- Single-clock buffer, successor to the team's LIFO.
- Storage order is selected at run time: LIFO (stack) or FIFO (queue).
- Adds registered read data with a valid strobe, simultaneous push/pop, programmable almost-full/almost-empty levels, and sticky overflow/underflow flags.
- Sits between producer and consumer blocks as a general-purpose scratch buffer.

Parameters:
- data_width, 32: word width in bits.
- buf_depth, 12: log2 of capacity; capacity = 2**buf_depth words.
- af_level, 2**buf_depth-4: almost_full asserts when use_words >= af_level.
- ae_level, 4: almost_empty asserts when use_words <= ae_level.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush, active high.
- mode  in  1  requested order: 0 = LIFO, 1 = FIFO.
- wr  in  1  write request.
- data_in  in  data_width  write data.
- rd  in  1  read request.
- data_out  out  data_width  read data, registered.
- data_valid  out  1  one-cycle strobe qualifying data_out.
- full  out  1  use_words == 2**buf_depth.
- empty  out  1  use_words == 0.
- almost_full  out  1  see af_level.
- almost_empty  out  1  see ae_level.
- use_words  out  buf_depth+1  current occupancy, 0 to 2**buf_depth.
- cur_mode  out  1  effective mode.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (reset=1 at a rising edge) forces:
  - count, pointers, data_out = 0; data_valid = 0;
  - overflow = underflow = 0; cur_mode = 0.
  - Resulting outputs: empty = 1, full = 0, almost_empty = 1.
  - reset overrides every other input, including mid-operation.
- clear has next priority:
  - count and pointers go to 0; overflow and underflow go to 0; data_valid = 0 next cycle.
  - wr and rd in the same cycle are dropped.
  - cur_mode loads mode.
- Acceptance rules:
  - rd_acc = rd & !empty.
  - wr_acc = wr & (!full | rd_acc).
  - Write while full is accepted only together with an accepted read.
- Error flags:
  - wr & !wr_acc sets overflow.
  - rd & empty sets underflow.
  - Both stay set until reset or clear.
- Read latency is 1 cycle:
  - rd_acc in cycle N gives data_valid = 1 with data_out in cycle N+1.
  - data_out holds its value when data_valid = 0.
- Status outputs are combinational from the count register and reflect accepted operations one cycle after the edge.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- LIFO pointer rules (stack pointer = count):
  - push writes mem[count].
  - pop reads mem[count-1].
  - Push+pop reads and writes mem[count-1] in the same cycle. The read returns the old top; the new word replaces it.
- FIFO pointer rules:
  - Separate wr_ptr and rd_ptr, buf_depth bits each, wrapping modulo 2**buf_depth.
  - Push+pop on full or non-empty advances both pointers.
  - Read data is the oldest word.
- Memory: simple dual-port, read-first, registered read. A same-address read and write returns the old data.
- Mode switching:
  - cur_mode loads mode in any cycle with count == 0 and wr = 0, or on clear.
  - A mode change requested while non-empty has no effect until the buffer drains.
  - No word is ever reordered under a mode change.
  - On a LIFO-to-FIFO switch, FIFO pointers restart at 0.
- Boundaries:
  - use_words reaches exactly 2**buf_depth when full.
  - Pointer wrap in FIFO mode is seamless.
  - rd on empty with a simultaneous wr: the write is accepted, the read is rejected and sets underflow, and there is no bypass.

Decomposition:
- Package sc_buf_pkg holds:
  - mode_t enum: MODE_LIFO = 1'b0, MODE_FIFO = 1'b1;
  - a function computing the default af_level from buf_depth.
- Sub-module sc_ram_rf: parametrised (data_width, buf_depth) simple dual-port read-first RAM with registered read.
- Top level holds the pointer, count, mode, and flag logic.

Test Plan:
All scenarios use buf_depth = 2 (capacity 4), af_level = 3, ae_level = 1.
- LIFO order: mode=0; push 0x11, 0x22, 0x33; then 3 pops -> data_out 0x33, 0x22, 0x11, each with data_valid one cycle after rd; final empty=1, use_words=0.
- FIFO order: mode=1 while empty; push 0xA, 0xB, 0xC; pop 3 -> 0xA, 0xB, 0xC; then 6 push/pop pairs cross the pointer wrap with order preserved.
- Full boundary: LIFO, push 1, 2, 3, 4 -> full=1, almost_full=1, use_words=4. Lone wr 0x55 -> overflow=1, use_words=4. Then wr 0x66 + rd together -> data_out=4, use_words=4. Next pop -> 0x66.
- Underflow: empty, rd=1 for one cycle -> underflow=1, data_valid stays 0. Same-cycle wr 0x77 + rd on empty -> use_words=1; next pop -> 0x77.
- Deferred mode change: LIFO holding 0x1, 0x2; drive mode=1 -> cur_mode stays 0 and pops give 0x2, 0x1. cur_mode becomes 1 in the first idle cycle after empty.
- Clear and reset mid-operation:
  - 3 entries, overflow set; clear=1 with wr=1 -> next cycle use_words=0, empty=1, overflow=0, wr dropped.
  - reset=1 during a pop -> data_valid=0, data_out=0 next cycle.
